// File: rtl/bus_dev_fifo_if.sv
// ============================================================================
// Module      : bus_dev_fifo_if
// Description : Host-side and arbiter-side handshake bundle of bus_dev_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bus_dev_fifo_if #(
  parameter int pckg_sz = 16,
  parameter int depth   = 8
) ();
  logic                     tx_valid;
  logic [pckg_sz-1:0]       tx_data;
  logic                     tx_ready;
  logic                     pndng;
  logic [pckg_sz-1:0]       D_pop;
  logic                     pop;
  logic                     push;
  logic [pckg_sz-1:0]       D_push;
  logic                     rx_valid;
  logic [pckg_sz-1:0]       rx_data;
  logic                     rx_ready;
  logic [$clog2(depth):0]   tx_count;
  logic [$clog2(depth):0]   rx_count;
  logic [7:0]               rx_drop_cnt;
  logic                     pop_err;

  // The queue itself
  modport slave (
    input  tx_valid, tx_data, pop, push, D_push, rx_ready,
    output tx_ready, pndng, D_pop, rx_valid, rx_data,
           tx_count, rx_count, rx_drop_cnt, pop_err
  );

  // Host logic plus arbiter port, seen from outside the queue
  modport master (
    output tx_valid, tx_data, pop, push, D_push, rx_ready,
    input  tx_ready, pndng, D_pop, rx_valid, rx_data,
           tx_count, rx_count, rx_drop_cnt, pop_err
  );
endinterface

`default_nettype wire

// File: rtl/bus_dev_fifo.sv
// ============================================================================
// Module      : bus_dev_fifo
// Description : Per-device TX/RX FWFT queues with destination-ID filtering.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bus_dev_fifo #(
  parameter int         pckg_sz   = 16,
  parameter int         depth     = 8,
  parameter logic [7:0] id        = 8'd0,
  parameter logic [7:0] broadcast = 8'hFF
) (
  input  wire logic      clk,
  input  wire logic      reset,
  bus_dev_fifo_if.slave  bus
);

  localparam int AW = $clog2(depth);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] c_full = CW'(depth);

  logic [pckg_sz-1:0] tx_mem_q [depth];
  logic [pckg_sz-1:0] tx_mem_d [depth];
  logic [pckg_sz-1:0] rx_mem_q [depth];
  logic [pckg_sz-1:0] rx_mem_d [depth];

  logic [AW-1:0] tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
  logic [AW-1:0] rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [7:0]    drop_q, drop_d;
  logic          perr_q, perr_d;
  logic          rdy_q, rdy_d;

  logic          tx_wr, tx_rd, rx_wr, rx_rd, rx_acc;
  logic [7:0]    rx_dst;

  // rdy_q holds tx_ready low through reset and releases it one edge later
  assign bus.tx_ready    = rdy_q && (tx_cnt_q != c_full);
  assign bus.pndng       = (tx_cnt_q != '0);
  assign bus.D_pop       = bus.pndng ? tx_mem_q[tx_rp_q] : '0;
  assign bus.rx_valid    = (rx_cnt_q != '0);
  assign bus.rx_data     = bus.rx_valid ? rx_mem_q[rx_rp_q] : '0;
  assign bus.tx_count    = tx_cnt_q;
  assign bus.rx_count    = rx_cnt_q;
  assign bus.rx_drop_cnt = drop_q;
  assign bus.pop_err     = perr_q;

  always_comb begin
    tx_wr    = bus.tx_valid && bus.tx_ready;
    tx_rd    = bus.pop && bus.pndng;
    rx_dst   = bus.D_push[pckg_sz-1 -: 8];
    rx_acc   = bus.push && ((rx_dst == id) || (rx_dst == broadcast));
    rx_rd    = bus.rx_valid && bus.rx_ready;
    // A full RX queue still takes a packet when the host frees a slot this cycle
    rx_wr    = rx_acc && ((rx_cnt_q != c_full) || rx_rd);

    tx_mem_d = tx_mem_q;
    rx_mem_d = rx_mem_q;
    tx_wp_d  = tx_wp_q;
    tx_rp_d  = tx_rp_q;
    rx_wp_d  = rx_wp_q;
    rx_rp_d  = rx_rp_q;
    tx_cnt_d = tx_cnt_q;
    rx_cnt_d = rx_cnt_q;
    drop_d   = drop_q;
    perr_d   = perr_q | (bus.pop && !bus.pndng);
    rdy_d    = 1'b1;

    if (tx_wr) begin
      tx_mem_d[tx_wp_q] = bus.tx_data;
      tx_wp_d           = tx_wp_q + AW'(1);
    end
    if (tx_rd) tx_rp_d = tx_rp_q + AW'(1);
    if (tx_wr && !tx_rd) tx_cnt_d = tx_cnt_q + CW'(1);
    if (!tx_wr && tx_rd) tx_cnt_d = tx_cnt_q - CW'(1);

    if (rx_wr) begin
      rx_mem_d[rx_wp_q] = bus.D_push;
      rx_wp_d           = rx_wp_q + AW'(1);
    end
    if (rx_rd) rx_rp_d = rx_rp_q + AW'(1);
    if (rx_wr && !rx_rd) rx_cnt_d = rx_cnt_q + CW'(1);
    if (!rx_wr && rx_rd) rx_cnt_d = rx_cnt_q - CW'(1);

    if (rx_acc && !rx_wr && (drop_q != 8'hFF)) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      tx_cnt_q <= '0;
      rx_cnt_q <= '0;
      drop_q   <= '0;
      perr_q   <= 1'b0;
      rdy_q    <= 1'b0;
    end else begin
      tx_wp_q  <= tx_wp_d;
      tx_rp_q  <= tx_rp_d;
      rx_wp_q  <= rx_wp_d;
      rx_rp_q  <= rx_rp_d;
      tx_cnt_q <= tx_cnt_d;
      rx_cnt_q <= rx_cnt_d;
      drop_q   <= drop_d;
      perr_q   <= perr_d;
      rdy_q    <= rdy_d;
    end
  end

  // Storage needs no reset: heads are masked to zero while a queue is empty
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

`default_nettype wire
